// File: rtl/simon_64_96.sv
// SIMON64/96 block cipher engine: iterative, one round (or one key-schedule
// step) per clock, with all 42 round keys held in a register array.
// Optional build macro: SIMON_MODE_OUT_EN drives the state code on `mode`;
// when it is not defined, `mode` is tied to 4'h0.
module simon_64_96 #(
  parameter int N  = 32,
  parameter int M  = 3,
  parameter int T  = 42,
  parameter int Co = 6
) (
  input  logic                  clk,
  input  logic                  nR,
  input  logic                  newData,
  input  logic                  newKey,
  input  logic                  enc_dec,
  input  logic                  readData,
  input  logic [1:0][N-1:0]     BLOCK,
  input  logic [M-1:0][N-1:0]   KEY,
  output logic                  loadData,
  output logic                  loadKey,
  output logic                  doneData,
  output logic                  doneKey,
  output logic [1:0][N-1:0]     outData,
  output logic [3:0]            mode
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_KEYEXP = 2'd1,
    ST_ROUND  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // z2 sequence, leftmost character is index 0 (bit 61 here)
  localparam logic [61:0]  Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
  // Key schedule constant: ~k[i] ^ 3 folded into a single xor mask
  localparam logic [N-1:0] KC = ~{{(N-2){1'b0}}, 2'b11};

  function automatic logic [N-1:0] rotl(input logic [N-1:0] v, input int s);
    return (v << s) | (v >> (N - s));
  endfunction

  function automatic logic [N-1:0] rotr(input logic [N-1:0] v, input int s);
    return (v >> s) | (v << (N - s));
  endfunction

  function automatic logic [N-1:0] simon_f(input logic [N-1:0] v);
    return (rotl(v, 1) & rotl(v, 8)) ^ rotl(v, 2);
  endfunction

  state_t              state_q, state_d;
  logic [Co-1:0]       cnt_q, cnt_d;
  logic [N-1:0]        x_q, x_d, y_q, y_d;
  logic                enc_q, enc_d;
  logic [1:0][N-1:0]   out_q, out_d;
  logic                load_data_q, load_data_d;
  logic                load_key_q, load_key_d;
  logic                done_data_q, done_data_d;
  logic                done_key_q, done_key_d;
  logic [N-1:0]        key_q [T];
  logic [N-1:0]        key_d [T];

  logic [N-1:0]        tmp_s, rk_s, nx_s, ny_s;
  logic [Co-1:0]       rk_idx_s;

  // Next-state logic: command decode in IDLE, key schedule, rounds, result hand-off
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    x_d         = x_q;
    y_d         = y_q;
    enc_d       = enc_q;
    out_d       = out_q;
    load_data_d = 1'b0;
    load_key_d  = 1'b0;
    done_data_d = done_data_q;
    done_key_d  = done_key_q;
    key_d       = key_q;
    tmp_s       = '0;
    rk_idx_s    = enc_q ? cnt_q : (Co'(T - 1) - cnt_q);
    rk_s        = key_q[rk_idx_s];
    nx_s        = x_q;
    ny_s        = y_q;

    case (state_q)
      ST_IDLE: begin
        if (newKey) begin
          // A new key always wins over a pending block
          for (int j = 0; j < M; j++) begin
            key_d[j] = KEY[j];
          end
          load_key_d = 1'b1;
          done_key_d = 1'b0;
          cnt_d      = '0;
          state_d    = ST_KEYEXP;
        end else if (newData && done_key_q) begin
          x_d         = BLOCK[1];
          y_d         = BLOCK[0];
          enc_d       = enc_dec;
          load_data_d = 1'b1;
          cnt_d       = '0;
          state_d     = ST_ROUND;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_KEYEXP: begin
        tmp_s = rotr(key_q[cnt_q + Co'(M - 1)], 3);
        tmp_s = tmp_s ^ rotr(tmp_s, 1);
        key_d[cnt_q + Co'(M)] = KC ^ {{(N-1){1'b0}}, Z2[Co'(61) - cnt_q]}
                                   ^ key_q[cnt_q] ^ tmp_s;
        if (cnt_q == Co'(T - M - 1)) begin
          done_key_d = 1'b1;
          cnt_d      = '0;
          state_d    = ST_IDLE;
        end else begin
          cnt_d = cnt_q + Co'(1);
        end
      end

      ST_ROUND: begin
        if (enc_q) begin
          nx_s = y_q ^ simon_f(x_q) ^ rk_s;
          ny_s = x_q;
        end else begin
          nx_s = y_q;
          ny_s = x_q ^ simon_f(y_q) ^ rk_s;
        end
        x_d = nx_s;
        y_d = ny_s;
        if (cnt_q == Co'(T - 1)) begin
          // Result is published in the same edge as the last round
          out_d       = {nx_s, ny_s};
          done_data_d = 1'b1;
          cnt_d       = '0;
          state_d     = ST_DONE;
        end else begin
          cnt_d = cnt_q + Co'(1);
        end
      end

      ST_DONE: begin
        if (readData) begin
          done_data_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!nR) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      enc_q       <= 1'b0;
      out_q       <= '0;
      load_data_q <= 1'b0;
      load_key_q  <= 1'b0;
      done_data_q <= 1'b0;
      done_key_q  <= 1'b0;
      for (int i = 0; i < T; i++) begin
        key_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      x_q         <= x_d;
      y_q         <= y_d;
      enc_q       <= enc_d;
      out_q       <= out_d;
      load_data_q <= load_data_d;
      load_key_q  <= load_key_d;
      done_data_q <= done_data_d;
      done_key_q  <= done_key_d;
      for (int i = 0; i < T; i++) begin
        key_q[i] <= key_d[i];
      end
    end
  end

  assign loadData = load_data_q;
  assign loadKey  = load_key_q;
  assign doneData = done_data_q;
  assign doneKey  = done_key_q;
  assign outData  = out_q;

`ifdef SIMON_MODE_OUT_EN
  assign mode = {2'b00, state_q};
`else
  assign mode = 4'h0;
`endif

endmodule

// File: tb/tb_simon_64_96.sv
// Self-checking bench for simon_64_96: published vector, table of blocks,
// random keys/blocks against a behavioural model, handshake and reset corners.
module tb_simon_64_96;

  logic             clk = 1'b0;
  logic             nR, newData, newKey, enc_dec, readData;
  logic [1:0][31:0] BLOCK;
  logic [2:0][31:0] KEY;
  logic             loadData, loadKey, doneData, doneKey;
  logic [1:0][31:0] outData;
  logic [3:0]       mode;

`ifdef SIMON_MODE_OUT_EN
  localparam bit MODE_EN = 1'b1;
`else
  localparam bit MODE_EN = 1'b0;
`endif

  simon_64_96 dut (
    .clk(clk), .nR(nR), .newData(newData), .newKey(newKey), .enc_dec(enc_dec),
    .readData(readData), .BLOCK(BLOCK), .KEY(KEY), .loadData(loadData),
    .loadKey(loadKey), .doneData(doneData), .doneKey(doneKey),
    .outData(outData), .mode(mode)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // ---------------- behavioural reference model ----------------
  logic [31:0] rk_m [42];
  string z2_m = "10101111011100000011010010011000101000010001111110010110110011";

  function automatic logic [31:0] rol(input logic [31:0] v, input int s);
    return (v << s) | (v >> (32 - s));
  endfunction

  function automatic logic [31:0] fmix(input logic [31:0] v);
    return (rol(v, 1) & rol(v, 8)) ^ rol(v, 2);
  endfunction

  function automatic void ref_keys(input logic [31:0] k0, k1, k2);
    logic [31:0] t;
    rk_m[0] = k0; rk_m[1] = k1; rk_m[2] = k2;
    for (int i = 0; i < 39; i++) begin
      t = rol(rk_m[i+2], 29);
      t = t ^ rol(t, 31);
      rk_m[i+3] = 32'hFFFFFFFC ^ ((z2_m[i] == "1") ? 32'd1 : 32'd0) ^ rk_m[i] ^ t;
    end
  endfunction

  function automatic logic [63:0] ref_enc(input logic [63:0] b);
    logic [31:0] x, y, t;
    x = b[63:32]; y = b[31:0];
    for (int i = 0; i < 42; i++) begin
      t = x;
      x = y ^ fmix(x) ^ rk_m[i];
      y = t;
    end
    return {x, y};
  endfunction

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    nR = 1'b0; newData = 1'b0; newKey = 1'b0; readData = 1'b0;
    tick(); tick();
    nR = 1'b1;
  endtask

  task automatic load_key(input logic [31:0] k2, k1, k0);
    int n;
    KEY = {k2, k1, k0};
    newKey = 1'b1;
    tick();
    chk("loadKey pulse", loadKey, 1'b1);
    chk("doneKey cleared on load", doneKey, 1'b0);
    chk("mode KEYEXP", mode, MODE_EN ? 4'h1 : 4'h0);
    newKey = 1'b0;
    tick();
    chk("loadKey one cycle", loadKey, 1'b0);
    n = 1;
    while (!doneKey && n < 100) begin
      tick();
      n++;
    end
    chk("key expansion latency", n, 39);
    ref_keys(k0, k1, k2);
  endtask

  task automatic run_block(input logic [63:0] blk, input logic enc, output logic [63:0] res);
    int n;
    BLOCK = blk; enc_dec = enc; newData = 1'b1;
    tick();
    chk("loadData pulse", loadData, 1'b1);
    newData = 1'b0;
    n = 0;
    while (!doneData && n < 100) begin
      tick();
      n++;
    end
    chk("data latency", n, 42);
    chk("mode DONE", mode, MODE_EN ? 4'h3 : 4'h0);
    res = outData;
  endtask

  task automatic read_out();
    readData = 1'b1;
    tick();
    chk("doneData cleared by readData", doneData, 1'b0);
    readData = 1'b0;
  endtask

  typedef struct {
    logic [63:0] pt;
    logic [63:0] ct;
  } vec_t;

  vec_t        tbl [5];
  logic [63:0] res, saved, pt, other;
  logic [31:0] rk0, rk1, rk2;
  bit          any_load;
  int          n;

  initial begin
    nR = 1'b0; newData = 1'b0; newKey = 1'b0; enc_dec = 1'b1; readData = 1'b0;
    BLOCK = '0; KEY = '0;

    // Table: published vector plus four more plaintexts under the standard key
    ref_keys(32'h03020100, 32'h0B0A0908, 32'h13121110);
    tbl[0].pt = 64'h6F7220676E696C63; tbl[0].ct = 64'h5CA2E27F111A8FC8;
    tbl[1].pt = 64'hA8D5F7DE0123FEDC;
    tbl[2].pt = 64'h5BC92D014567BA98;
    tbl[3].pt = 64'hF2B48D4589AB7654;
    tbl[4].pt = 64'h567F11DECDEF3210;
    for (int i = 1; i < 5; i++) tbl[i].ct = ref_enc(tbl[i].pt);

    // Reset state
    do_reset();
    chk("reset loadData", loadData, 1'b0);
    chk("reset loadKey", loadKey, 1'b0);
    chk("reset doneData", doneData, 1'b0);
    chk("reset doneKey", doneKey, 1'b0);
    chk("reset outData", outData, 64'h0);
    chk("reset mode", mode, 4'h0);

    // Key load and published encrypt vector
    load_key(32'h13121110, 32'h0B0A0908, 32'h03020100);
    run_block(64'h6F7220676E696C63, 1'b1, res);
    chk("known encrypt", res, 64'h5CA2E27F111A8FC8);

    // newData held in DONE without readData: no load, outData stable
    saved = outData;
    other = 64'hA8D5F7DE0123FEDC;
    BLOCK = other; enc_dec = 1'b1; newData = 1'b1;
    any_load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      any_load |= loadData;
      chk("outData held in DONE", outData, saved);
    end
    chk("no load while DONE", any_load, 1'b0);
    chk("doneData held", doneData, 1'b1);
    readData = 1'b1;
    tick();
    chk("doneData cleared", doneData, 1'b0);
    chk("no load on read edge", loadData, 1'b0);
    readData = 1'b0;
    tick();
    chk("pending block loads in IDLE", loadData, 1'b1);
    newData = 1'b0;
    n = 0;
    while (!doneData && n < 100) begin
      tick();
      n++;
      if (n == 10) chk("outData held during ROUND", outData, saved);
    end
    chk("pending block latency", n, 42);
    chk("pending block result", outData, tbl[1].ct);
    read_out();

    // Published decrypt after reset and rekey
    do_reset();
    load_key(32'h13121110, 32'h0B0A0908, 32'h03020100);
    run_block(64'h5CA2E27F111A8FC8, 1'b0, res);
    chk("known decrypt", res, 64'h6F7220676E696C63);
    read_out();

    // Table: encrypt five blocks back to back, then decrypt after reset
    for (int i = 0; i < 5; i++) begin
      run_block(tbl[i].pt, 1'b1, res);
      chk("table encrypt", res, tbl[i].ct);
      read_out();
    end
    do_reset();
    load_key(32'h13121110, 32'h0B0A0908, 32'h03020100);
    for (int i = 0; i < 5; i++) begin
      run_block(tbl[i].ct, 1'b0, res);
      chk("table decrypt", res, tbl[i].pt);
      read_out();
    end

    // Random keys and blocks against the model
    for (int r = 0; r < 3; r++) begin
      rk0 = $urandom; rk1 = $urandom; rk2 = $urandom;
      load_key(rk2, rk1, rk0);
      pt = {$urandom, $urandom};
      run_block(pt, 1'b1, res);
      chk("random encrypt", res, ref_enc(pt));
      read_out();
      run_block(res, 1'b0, res);
      chk("random decrypt", res, pt);
      read_out();
    end

    // newKey beats newData in IDLE
    rk0 = $urandom; rk1 = $urandom; rk2 = $urandom;
    KEY = {rk2, rk1, rk0};
    BLOCK = 64'h0123456789ABCDEF; enc_dec = 1'b1;
    newKey = 1'b1; newData = 1'b1;
    tick();
    chk("priority loadKey", loadKey, 1'b1);
    chk("priority loadData", loadData, 1'b0);
    newKey = 1'b0; newData = 1'b0;
    n = 0;
    while (!doneKey && n < 100) begin
      tick();
      n++;
    end
    chk("priority key latency", n, 39);
    ref_keys(rk0, rk1, rk2);
    run_block(64'h0123456789ABCDEF, 1'b1, res);
    chk("priority key encrypt", res, ref_enc(64'h0123456789ABCDEF));

    // Reset mid-ROUND clears everything; newData afterwards is left pending
    read_out();
    BLOCK = 64'hFEDCBA9876543210; enc_dec = 1'b1; newData = 1'b1;
    tick();
    chk("mid-round start load", loadData, 1'b1);
    newData = 1'b0;
    repeat (10) tick();
    nR = 1'b0;
    tick();
    chk("mid reset loadData", loadData, 1'b0);
    chk("mid reset loadKey", loadKey, 1'b0);
    chk("mid reset doneData", doneData, 1'b0);
    chk("mid reset doneKey", doneKey, 1'b0);
    chk("mid reset outData", outData, 64'h0);
    chk("mid reset mode", mode, 4'h0);
    nR = 1'b1;
    newData = 1'b1;
    any_load = 1'b0;
    repeat (60) begin
      tick();
      any_load |= loadData | doneData;
    end
    chk("no load without key", any_load, 1'b0);
    newData = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/simon_64_96.md
SIMON_64_96 -- requirements
Module: simon_64_96

Interface
REQ-001 SHALL have parameters: N, default 32, word width; M, default 3, key words; T, default 42, rounds; Co, default 6, round/key counter width.
REQ-002 SHALL have one clock and a synchronous, active-low reset, named as follows: clk  input  1  clock, all logic on rising edge; nR  input  1  synchronous active-low reset.
REQ-003 SHALL have these ports:
- newData  input  1  block available on BLOCK.
- newKey  input  1  key available on KEY.
- enc_dec  input  1  1=encrypt, 0=decrypt; sampled at block load.
- readData  input  1  host has taken outData.
- BLOCK  input  [1:0][N-1:0]  BLOCK[1]=x (upper), BLOCK[0]=y (lower).
- KEY  input  [M-1:0][N-1:0]  KEY[0]=k0 … KEY[2]=k2.
- loadData  output  1  one-cycle pulse, BLOCK captured.
- loadKey  output  1  one-cycle pulse, KEY captured.
- doneData  output  1  outData valid.
- doneKey  output  1  round keys ready.
- outData  output  [1:0][N-1:0]  result, same word order as BLOCK.
- mode  output  4  state code.

Function
REQ-004 SHALL implement SIMON64/96: f(x)=(x<<<1 & x<<<8) ^ (x<<<2), all 32-bit rotates.
REQ-005 SHALL apply encrypt rounds i=0..41 as (x,y) <= (y ^ f(x) ^ k[i], x).
REQ-006 SHALL apply decrypt rounds i=41..0 as (x,y) <= (y, x ^ f(y) ^ k[i]).
REQ-007 SHALL expand keys for i=0..38: tmp=(k[i+2]>>>3); tmp^=tmp>>>1; k[i+3]=32'hFFFFFFFC ^ z2[i mod 62] ^ k[i] ^ tmp.
REQ-008 SHALL use z2=10101111011100000011010010011000101000010001111110010110110011, leftmost bit = index 0.
REQ-009 SHALL store all 42 round keys in a register array.
REQ-010 SHALL use states IDLE(0), KEYEXP(1), ROUND(2), DONE(3), reported on mode.
REQ-011 SHALL, in IDLE with newKey=1, capture KEY into k[0..2], pulse loadKey for 1 cycle, clear doneKey and enter KEYEXP.
REQ-012 SHALL, in KEYEXP, produce one key per cycle for 39 cycles, then set doneKey=1 and return to IDLE.
REQ-013 SHALL hold doneKey high until reset or a new key load.
REQ-014 SHALL, in IDLE with newData=1, doneKey=1 and newKey=0, capture BLOCK and enc_dec, pulse loadData for 1 cycle and enter ROUND.
REQ-015 SHALL give newKey priority over newData when both are asserted in IDLE.
REQ-016 SHALL leave newData pending (no load) while doneKey=0.
REQ-017 SHALL, in ROUND, perform one round per cycle for 42 cycles, then enter DONE with doneData=1 and outData=(x,y); doneData rises 42 cycles after loadData.
REQ-018 SHALL, in DONE, hold outData and doneData stable until readData=1, then clear doneData next edge and return to IDLE.
REQ-019 SHALL ignore newData, newKey and readData in states where they are not listed above; a block pending on newData loads on the first IDLE cycle.
REQ-020 SHALL hold outData at the last result outside DONE.

Reset
REQ-021 SHALL, when nR=0 at a rising clk, set state IDLE and clear loadData, loadKey, doneData, doneKey, outData, counters, data registers and round keys to 0, overriding any operation in progress.

Configuration
REQ-022 SHALL drive mode with the state code when SIMON_MODE_OUT_EN is defined, and tie mode to 4'h0 when it is not; cipher function is identical either way.

Verification
REQ-023 SHALL pass: reset, KEY={13121110,0B0A0908,03020100} with newKey -> loadKey pulse, doneKey high 39 cycles later.
REQ-024 SHALL pass: encrypt 6F7220676E696C63 -> outData=5CA2E27F111A8FC8, doneData 42 cycles after loadData.
REQ-025 SHALL pass: decrypt 5CA2E27F111A8FC8 after reset and rekey -> 6F7220676E696C63.
REQ-026 SHALL pass: five blocks encrypted back to back (A8D5F7DE0123FEDC, 5BC92D014567BA98, F2B48D4589AB7654, 567F11DECDEF3210 included), then decrypted after reset -> all original plaintexts recovered.
REQ-027 SHALL pass: newData held while doneData=1 and readData=0 -> no loadData and outData stable until readData.
REQ-028 SHALL pass: nR=0 mid-ROUND -> all outputs 0 next edge; newData without new key -> no load.
